// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the EX-stage divide controller.
// State encoding and one-hot div_op bit positions live here.
package div_ctrl_pkg;

   localparam int DATA_W = 32;
   localparam int OP_W   = 4;

   // one-hot div_op = {modu, mod, divu, div}
   localparam int OP_DIV  = 0;
   localparam int OP_DIVU = 1;
   localparam int OP_MOD  = 2;
   localparam int OP_MODU = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } div_state_e;

endpackage

// File: rtl/div_ctrl_if.sv
// Request/completion/abort handshake between the divide controller and
// the divider it drives.
interface div_ctrl_if;
   import div_ctrl_pkg::*;

   logic              div_req_valid;
   logic              div_req_ready;
   logic              div_signed;
   logic [DATA_W-1:0] div_x;
   logic [DATA_W-1:0] div_y;
   logic              div_res_valid;
   logic [DATA_W-1:0] div_quot;
   logic [DATA_W-1:0] div_rem;
   logic              div_cancel;

   modport master (
      output div_req_valid, div_signed, div_x, div_y, div_cancel,
      input  div_req_ready, div_res_valid, div_quot, div_rem
   );

   modport slave (
      input  div_req_valid, div_signed, div_x, div_y, div_cancel,
      output div_req_ready, div_res_valid, div_quot, div_rem
   );

endinterface

// File: rtl/div_ctrl.sv
// EX-stage divide sequencer: latches operands, hands them to an external
// divider, holds the selected result until MEM accepts, aborts on flush.
module div_ctrl
   import div_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              es_valid,
   input  logic [OP_W-1:0]   div_op,
   input  logic [DATA_W-1:0] src1,
   input  logic [DATA_W-1:0] src2,
   input  logic              ms_allowin,
   input  logic              flush,
   div_ctrl_if.master        div,
   output logic              div_ready_go,
   output logic [DATA_W-1:0] div_result
);

   div_state_e        state, state_nxt;
   logic              accept;
   logic              signed_q, sel_quot_q, cancel_q;
   logic [DATA_W-1:0] x_q, y_q, res_q;

   assign accept = es_valid & (|div_op) & ~flush;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = ST_REQ;
         ST_REQ: begin
            if (flush)                   state_nxt = ST_IDLE;
            else if (div.div_req_ready)  state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (flush)                   state_nxt = ST_IDLE;
            else if (div.div_res_valid)  state_nxt = ST_DONE;
         end
         ST_DONE: if (flush || ms_allowin) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         signed_q   <= 1'b0;
         sel_quot_q <= 1'b0;
         cancel_q   <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         res_q      <= '0;
      end else begin
         // abort only if the divider still owns work; a result arriving with
         // the flush means it has already finished
         cancel_q <= flush & ((state == ST_REQ) |
                              ((state == ST_WAIT) & ~div.div_res_valid));
         if (state == ST_IDLE && accept) begin
            x_q        <= src1;
            y_q        <= src2;
            signed_q   <= div_op[OP_DIV] | div_op[OP_MOD];
            sel_quot_q <= div_op[OP_DIV] | div_op[OP_DIVU];
         end
         if (state == ST_WAIT && div.div_res_valid && !flush)
            res_q <= sel_quot_q ? div.div_quot : div.div_rem;
      end
   end

   assign div.div_req_valid = (state == ST_REQ);
   assign div.div_signed    = signed_q;
   assign div.div_x         = x_q;
   assign div.div_y         = y_q;
   assign div.div_cancel    = cancel_q;

   assign div_ready_go = (div_op == '0) | (state == ST_DONE);
   assign div_result   = res_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: behavioural divider stub, directed corner cases plus
// randomized divides, results checked through an expected-value scoreboard.
module tb_div_ctrl;
   import div_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        es_valid = 1'b0;
   logic [3:0]  div_op = '0;
   logic [31:0] src1 = '0, src2 = '0;
   logic        ms_allowin = 1'b0;
   logic        flush = 1'b0;
   logic        div_ready_go;
   logic [31:0] div_result;

   div_ctrl_if dif();

   div_ctrl dut (
      .clk(clk), .rst(rst), .es_valid(es_valid), .div_op(div_op),
      .src1(src1), .src2(src2), .ms_allowin(ms_allowin), .flush(flush),
      .div(dif), .div_ready_go(div_ready_go), .div_result(div_result)
   );

   always #5 clk = ~clk;

   int          checks = 0, errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_res = '0;

   // divider stub knobs and state
   int          ready_delay = 0, res_lat = 1;
   bit          ignore_cancel = 0, spur = 0;
   int          sb_wait = 0, sb_cnt = 0;
   bit          sb_busy = 0, sb_sgn = 0;
   logic [31:0] sb_x = '0, sb_y = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // plain arithmetic divide; zero divisor gives all-ones quotient, dividend remainder
   function automatic logic [31:0] arith(bit sgn, bit quot, logic [31:0] a, logic [31:0] b);
      if (b == 32'h0) return quot ? 32'hFFFF_FFFF : a;
      if (sgn) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return quot ? a : 32'h0;
         return quot ? 32'($signed(a) / $signed(b)) : 32'($signed(a) % $signed(b));
      end
      return quot ? a / b : a % b;
   endfunction

   function automatic logic [31:0] ref_op(logic [3:0] op, logic [31:0] a, logic [31:0] b);
      case (op)
         4'b0001: return arith(1'b1, 1'b1, a, b);  // div
         4'b0010: return arith(1'b0, 1'b1, a, b);  // divu
         4'b0100: return arith(1'b1, 1'b0, a, b);  // mod
         4'b1000: return arith(1'b0, 1'b0, a, b);  // modu
         default: return 32'h0;
      endcase
   endfunction

   // divider stub: ready after ready_delay REQ cycles, result res_lat cycles later
   always @(negedge clk) begin
      dif.div_req_ready = 1'b0;
      dif.div_res_valid = 1'b0;
      if (rst || (dif.div_cancel && !ignore_cancel)) begin
         sb_busy = 0;
         sb_wait = 0;
      end else if (spur) begin
         dif.div_res_valid = 1'b1;
         dif.div_quot      = 32'hDEAD_BEEF;
         dif.div_rem       = 32'hDEAD_BEEF;
         spur = 0;
      end else if (sb_busy) begin
         if (sb_cnt == 0) begin
            dif.div_res_valid = 1'b1;
            dif.div_quot      = arith(sb_sgn, 1'b1, sb_x, sb_y);
            dif.div_rem       = arith(sb_sgn, 1'b0, sb_x, sb_y);
            sb_busy = 0;
         end else sb_cnt--;
      end else if (dif.div_req_valid) begin
         if (sb_wait >= ready_delay) begin
            dif.div_req_ready = 1'b1;
            sb_x = dif.div_x; sb_y = dif.div_y; sb_sgn = dif.div_signed;
            sb_busy = 1; sb_cnt = res_lat - 1; sb_wait = 0;
         end else sb_wait++;
      end
   end

   // scoreboard monitor: pops one expectation per DONE episode, then checks it is held
   bit          mon_in = 0;
   logic [31:0] mon_exp = '0;
   always begin
      @(posedge clk);
      #2;
      if (!rst && div_op != 4'h0 && div_ready_go) begin
         if (!mon_in) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL sb_unexpected: result %h with nothing expected", div_result);
            end else begin
               mon_exp = exp_q.pop_front();
               chk("sb_result", div_result, mon_exp);
            end
            mon_in = 1;
         end else chk("done_hold", div_result, mon_exp);
      end else mon_in = 0;
   end

   task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int rdly, input int rlat);
      @(negedge clk);
      if (div_op != 4'h0) chk("idle_ready_go", 32'(div_ready_go), 32'h0);
      ms_allowin = 1'b0; ready_delay = rdly; res_lat = rlat;
      es_valid = 1'b1; div_op = op; src1 = a; src2 = b;
      @(posedge clk);
      #1;
      src1 = $urandom; src2 = $urandom;
   endtask

   task automatic run_div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int rdly, input int rlat, input int hold);
      logic [31:0] e;
      bit          sgn;
      int          n;
      e   = ref_op(op, a, b);
      sgn = (op == 4'b0001) || (op == 4'b0100);
      exp_q.push_back(e);
      start_op(op, a, b, rdly, rlat);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (dif.div_req_valid) begin
            chk("req_x", dif.div_x, a);
            chk("req_y", dif.div_y, b);
            chk("req_signed", 32'(dif.div_signed), 32'(sgn));
         end
      end while (!div_ready_go && n < 200);
      chk("latency", 32'(n), 32'(rdly + rlat + 2));
      ms_allowin = (hold == 0);
      for (int i = 1; i <= hold; i++) begin
         @(negedge clk);
         chk("done_ready_go", 32'(div_ready_go), 32'h1);
         if (i == hold) ms_allowin = 1'b1;
      end
      @(posedge clk);
      #1;
      last_res = e;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cc;
      logic [3:0]  op;
      logic [31:0] a, b;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_req_valid", 32'(dif.div_req_valid), 32'h0);
      chk("rst_cancel", 32'(dif.div_cancel), 32'h0);
      chk("rst_signed", 32'(dif.div_signed), 32'h0);
      chk("rst_x", dif.div_x, 32'h0);
      chk("rst_y", dif.div_y, 32'h0);
      chk("rst_result", div_result, 32'h0);
      chk("rst_ready_go_nodiv", 32'(div_ready_go), 32'h1);
      div_op = 4'b0001; #1;
      chk("rst_ready_go_div", 32'(div_ready_go), 32'h0);
      div_op = 4'b0000;
      rst = 1'b0;

      run_div(4'b0001, 32'd100, 32'd7, 0, 1, 0);                  // ideal divider, 14
      run_div(4'b0100, 32'hFFFF_FFF9, 32'd2, 0, 1, 1);            // -7 mod 2
      run_div(4'b0010, 32'hFFFF_FFFF, 32'd2, 3, 1, 0);            // slow req_ready
      run_div(4'b1000, 32'd1000, 32'd7, 0, 2, 5);                 // long DONE hold
      run_div(4'b0001, 32'hFFFF_FF9C, 32'd7, 0, 1, 0);            // back-to-back
      run_div(4'b0010, 32'd55, 32'd0, 1, 2, 0);                   // zero divisor

      // flush while in DONE
      exp_q.push_back(32'd123);
      start_op(4'b0001, 32'd1234, 32'd10, 0, 1);
      repeat (3) @(negedge clk);
      chk("done_reached", 32'(div_ready_go), 32'h1);
      flush = 1'b1; es_valid = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      chk("fdone_ready_go", 32'(div_ready_go), 32'h0);
      chk("fdone_cancel", 32'(dif.div_cancel), 32'h0);
      chk("fdone_result", div_result, 32'd123);
      last_res = 32'd123;

      // flush in 2nd WAIT cycle; the divider keeps going and answers late
      start_op(4'b0001, 32'd50, 32'd5, 0, 5);
      ignore_cancel = 1;
      repeat (3) @(negedge clk);
      flush = 1'b1; es_valid = 1'b0;
      cc = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         flush = 1'b0;
         if (i == 0) chk("fwait_cancel", 32'(dif.div_cancel), 32'h1);
         cc += int'(dif.div_cancel);
         chk("fwait_req_valid", 32'(dif.div_req_valid), 32'h0);
         chk("fwait_ready_go", 32'(div_ready_go), 32'h0);
         chk("fwait_result", div_result, last_res);
      end
      chk("fwait_cancel_width", 32'(cc), 32'h1);
      ignore_cancel = 0;

      // flush coincident with res_valid
      start_op(4'b0010, 32'd77, 32'd3, 0, 2);
      repeat (3) @(negedge clk);
      flush = 1'b1; es_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         flush = 1'b0;
         chk("fres_cancel", 32'(dif.div_cancel), 32'h0);
         chk("fres_ready_go", 32'(div_ready_go), 32'h0);
         chk("fres_result", div_result, last_res);
      end

      // flush coincident with req_ready
      start_op(4'b0100, 32'd9, 32'd4, 1, 1);
      repeat (2) @(negedge clk);
      flush = 1'b1; es_valid = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      chk("freq_cancel", 32'(dif.div_cancel), 32'h1);
      chk("freq_req_valid", 32'(dif.div_req_valid), 32'h0);
      @(negedge clk);
      chk("freq_cancel_drop", 32'(dif.div_cancel), 32'h0);
      chk("freq_ready_go", 32'(div_ready_go), 32'h0);

      // flush in IDLE blocks acceptance, no cancel
      @(negedge clk);
      es_valid = 1'b1; div_op = 4'b0001; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; es_valid = 1'b0;
      chk("fidle_req_valid", 32'(dif.div_req_valid), 32'h0);
      chk("fidle_cancel", 32'(dif.div_cancel), 32'h0);

      // stray res_valid in IDLE is ignored
      @(posedge clk);
      #1 spur = 1;
      repeat (2) @(negedge clk);
      chk("spur_ready_go", 32'(div_ready_go), 32'h0);
      chk("spur_result", div_result, last_res);

      // reset mid-operation: no cancel, everything cleared
      start_op(4'b0001, 32'd200, 32'd3, 0, 4);
      repeat (2) @(negedge clk);
      rst = 1'b1; es_valid = 1'b0;
      @(negedge clk);
      chk("mrst_cancel", 32'(dif.div_cancel), 32'h0);
      chk("mrst_req_valid", 32'(dif.div_req_valid), 32'h0);
      chk("mrst_result", div_result, 32'h0);
      chk("mrst_x", dif.div_x, 32'h0);
      chk("mrst_ready_go", 32'(div_ready_go), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      last_res = 32'h0;
      @(negedge clk);
      chk("mrst_cancel_after", 32'(dif.div_cancel), 32'h0);

      // randomized back-to-back divides with idle gaps
      for (int k = 0; k < 40; k++) begin
         op = 4'b0001 << $urandom_range(3);
         a  = ($urandom_range(7) == 0) ? 32'h8000_0000 : 32'($urandom);
         case ($urandom_range(7))
            0:       b = 32'h0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = 32'($urandom_range(1, 16));
            default: b = 32'($urandom);
         endcase
         run_div(op, a, b, $urandom_range(3), $urandom_range(1, 6), $urandom_range(3));
         if ($urandom_range(3) == 0) begin
            @(negedge clk);
            es_valid = 1'b0; div_op = 4'h0; ms_allowin = 1'b0;
            #1 chk("gap_ready_go", 32'(div_ready_go), 32'h1);
         end
      end

      repeat (4) @(negedge clk);
      chk("sb_drained", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-002 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 The block SHALL have port es_valid, input, 1, meaning the EX stage holds a valid instruction.
REQ-004 The block SHALL have port div_op, input, 4, one-hot {modu, mod, divu, div}; all-zero means not a divide.
REQ-005 The block SHALL have ports src1 and src2, input, 32 each, the dividend and divisor.
REQ-006 The block SHALL have port ms_allowin, input, 1, meaning the MEM stage accepts the EX instruction this cycle.
REQ-007 The block SHALL have port flush, input, 1, the exception/ertn kill of the EX instruction.
REQ-008 The block SHALL have ports div_req_valid (output, 1), div_signed (output, 1), div_x (output, 32) and div_y (output, 32), carrying the divider request.
REQ-009 The block SHALL have port div_req_ready, input, 1, meaning the divider accepts the request.
REQ-010 The block SHALL have ports div_res_valid (input, 1), div_quot (input, 32) and div_rem (input, 32), carrying the divider completion.
REQ-011 The block SHALL have port div_cancel, output, 1, a one-cycle abort pulse to the divider.
REQ-012 The block SHALL have port div_ready_go, output, 1, the EX ready_go contribution.
REQ-013 The block SHALL have port div_result, output, 32, the selected quotient or remainder.

Function
REQ-014 The block SHALL use FSM states IDLE, REQ, WAIT, DONE.
REQ-015 IDLE: on es_valid & |div_op & !flush, the block SHALL latch src1, src2, div_signed = div_op[0]|div_op[2] and sel_quot = div_op[0]|div_op[1], then go to REQ next cycle.
REQ-016 REQ: the block SHALL assert div_req_valid with latched operands held stable; on div_req_ready it SHALL go to WAIT.
REQ-017 WAIT: on div_res_valid the block SHALL register div_result = sel_quot ? div_quot : div_rem and go to DONE.
REQ-018 DONE: the block SHALL hold div_result stable; on ms_allowin it SHALL go to IDLE.
REQ-019 div_ready_go SHALL be 1 when div_op==0 or state==DONE, and 0 otherwise.
REQ-020 Minimum latency SHALL be 3 cycles from IDLE acceptance to DONE, given req_ready on first REQ cycle and res_valid the cycle after; total latency SHALL be divider latency plus 2.
REQ-021 flush in REQ or WAIT SHALL force IDLE next cycle and pulse div_cancel for exactly one cycle.
REQ-022 flush in IDLE or DONE SHALL force IDLE with no cancel.
REQ-023 flush and div_res_valid in the same cycle SHALL make flush win: the result is discarded and cancel is not pulsed.
REQ-024 flush and div_req_ready in the same cycle in REQ SHALL make flush win, with a cancel pulse.
REQ-025 Divisor zero SHALL be passed through unchanged, with no special-casing; the result is whatever the divider returns.
REQ-026 div_res_valid outside WAIT SHALL be ignored.
REQ-027 Back-to-back divides SHALL be supported: IDLE re-accepts in the cycle after DONE exits.

Reset
REQ-028 rst SHALL force state IDLE, with div_req_valid, div_cancel, div_signed and sel_quot = 0, div_x, div_y and div_result = 0, and div_ready_go = 1 when div_op==0.
REQ-029 Reset mid-operation SHALL return to IDLE without a cancel pulse, since the divider shares rst.

Structure
REQ-030 The shared package SHALL hold the state encoding (2-bit) and the div_op bit-index constants.
REQ-031 The block SHALL have no sub-module; the divider is instantiated by the parent and connected through the REQ-008 to REQ-011 ports.

Verification
REQ-032 div, src1=100, src2=7, ideal divider -> div_result=14, div_ready_go high in DONE only.
REQ-033 mod, src1=-7 (0xFFFFFFF9), src2=2 -> div_result=0xFFFFFFFF, div_signed=1.
REQ-034 divu, src1=0xFFFFFFFF, src2=2, with div_req_ready delayed 3 cycles -> operands stable throughout REQ, div_result=0x7FFFFFFF.
REQ-035 flush in the 2nd WAIT cycle -> div_cancel high exactly 1 cycle, IDLE next, a later res_valid is ignored.
REQ-036 DONE with ms_allowin low for 5 cycles -> div_result and div_ready_go held; exit on the 6th cycle; an immediate second divide is accepted.
REQ-037 flush coincident with div_res_valid -> no cancel, IDLE, div_result unchanged.
